// File: rtl/axi_llc_repl_unit.sv
// Per-set replacement unit: picks hit/free/victim way, skipping SPM-locked ways, with tree-PLRU or LFSR policy.
// Optional saturating performance counters are built when AXI_LLC_REPL_PERF_EN is defined.
module axi_llc_repl_unit #(
   parameter int NumWays    = 8,
   parameter int NumSets    = 256,
   parameter int ReplPolicy = 0,
   parameter int IdxW       = $clog2(NumSets)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [IdxW-1:0]    req_index_i,
   input  logic               req_hit_i,
   input  logic [NumWays-1:0] req_hit_way_i,
   input  logic [NumWays-1:0] req_valid_ways_i,
   input  logic [NumWays-1:0] req_dirty_ways_i,
   input  logic [NumWays-1:0] req_spm_lock_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [NumWays-1:0] rsp_way_o,
   output logic               rsp_evict_o,
   output logic               rsp_no_way_o,
   output logic               init_done_o,
   output logic [31:0]        perf_hit_o,
   output logic [31:0]        perf_miss_o,
   output logic [31:0]        perf_wb_o
);

   localparam int LvlW = $clog2(NumWays);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             state_reg;
   logic [IdxW-1:0]    cnt_reg;
   logic               init_done_reg;
   logic [15:0]        lfsr_reg;
   logic               rsp_valid_reg;
   logic [NumWays-1:0] rsp_way_reg;
   logic               rsp_evict_reg;
   logic               rsp_no_way_reg;

   logic               acc;
   logic [NumWays-2:0] plru_rd;
   logic [NumWays-2:0] plru_next;
   logic [LvlW-1:0]    hit_idx;
   logic [LvlW-1:0]    free_idx;
   logic               free_found;
   logic [LvlW-1:0]    rand_idx;
   logic [LvlW-1:0]    rand_cand;
   logic [LvlW-1:0]    tree_idx;
   logic [LvlW-1:0]    walk_node;
   logic [LvlW-1:0]    walk_lo;
   logic               walk_hi;
   logic [NumWays-1:0] lo_mask;
   logic [NumWays-1:0] hi_mask;
   logic [LvlW-1:0]    sel_idx;
   logic [NumWays-1:0] sel_way;
   logic               sel_evict;
   logic               sel_no_way;
   logic               sel_upd;
   logic [LvlW-1:0]    upd_node;
   logic [LvlW-1:0]    upd_shift;

   assign req_ready_o  = (state_reg == ST_RUN) && (!rsp_valid_reg || rsp_ready_i);
   assign acc          = req_valid_i && req_ready_o;
   assign rsp_valid_o  = rsp_valid_reg;
   assign rsp_way_o    = rsp_way_reg;
   assign rsp_evict_o  = rsp_evict_reg;
   assign rsp_no_way_o = rsp_no_way_reg;
   assign init_done_o  = init_done_reg;

   // Encoders: hit way index, lowest free unlocked way, first unlocked way from the LFSR start.
   always_comb begin
      hit_idx    = '0;
      free_idx   = '0;
      free_found = 1'b0;
      rand_idx   = '0;
      rand_cand  = '0;
      for (int i = 0; i < NumWays; i++) begin
         if (req_hit_way_i[i]) hit_idx = LvlW'(i);
      end
      for (int i = NumWays - 1; i >= 0; i--) begin
         if (!req_valid_ways_i[i] && !req_spm_lock_i[i]) begin
            free_found = 1'b1;
            free_idx   = LvlW'(i);
         end
      end
      for (int k = NumWays - 1; k >= 0; k--) begin
         rand_cand = lfsr_reg[LvlW-1:0] + LvlW'(k);
         if (!req_spm_lock_i[rand_cand]) rand_idx = rand_cand;
      end
   end

   // Tree walk; a subtree whose ways are all locked is never entered.
   always_comb begin
      walk_node = '0;
      walk_lo   = '0;
      walk_hi   = 1'b0;
      lo_mask   = '0;
      hi_mask   = '0;
      for (int l = 0; l < LvlW; l++) begin
         lo_mask = ({NumWays{1'b1}} >> (NumWays - (NumWays >> (l + 1)))) << walk_lo;
         hi_mask = lo_mask << (NumWays >> (l + 1));
         walk_hi = plru_rd[walk_node];
         if (walk_hi && ((req_spm_lock_i & hi_mask) == hi_mask)) walk_hi = 1'b0;
         else if (!walk_hi && ((req_spm_lock_i & lo_mask) == lo_mask)) walk_hi = 1'b1;
         if (walk_hi) walk_lo = walk_lo + LvlW'(NumWays >> (l + 1));
         walk_node = walk_node + walk_node + LvlW'(1) + LvlW'(walk_hi);
      end
      tree_idx = walk_lo;
   end

   always_comb begin
      sel_idx    = '0;
      sel_way    = '0;
      sel_evict  = 1'b0;
      sel_no_way = 1'b0;
      sel_upd    = 1'b0;
      if (req_hit_i) begin
         sel_idx = hit_idx;
         sel_way = req_hit_way_i;
         sel_upd = 1'b1;
      end else if (&req_spm_lock_i) begin
         sel_no_way = 1'b1;
      end else if (free_found) begin
         sel_idx = free_idx;
         sel_way = {{(NumWays-1){1'b0}}, 1'b1} << free_idx;
         sel_upd = 1'b1;
      end else begin
         sel_idx   = (ReplPolicy == 1) ? rand_idx : tree_idx;
         sel_way   = {{(NumWays-1){1'b0}}, 1'b1} << sel_idx;
         sel_evict = req_dirty_ways_i[sel_idx];
         sel_upd   = 1'b1;
      end
   end

   // Every node on the accessed path points away from the accessed way.
   always_comb begin
      plru_next = plru_rd;
      upd_node  = '0;
      upd_shift = '0;
      for (int l = 0; l < LvlW; l++) begin
         upd_shift           = sel_idx << l;
         plru_next[upd_node] = !upd_shift[LvlW-1];
         upd_node            = upd_node + upd_node + LvlW'(1) + LvlW'(upd_shift[LvlW-1]);
      end
   end

   generate
      if (ReplPolicy == 0) begin : g_plru
         logic [NumWays-2:0] plru_mem [NumSets];

         always_ff @(posedge clk_i) begin
            if (state_reg == ST_INIT) plru_mem[cnt_reg] <= '0;
            else if (acc && sel_upd)  plru_mem[req_index_i] <= plru_next;
         end

         assign plru_rd = plru_mem[req_index_i];
      end else begin : g_no_plru
         assign plru_rd = '0;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= ST_INIT;
         cnt_reg        <= '0;
         init_done_reg  <= 1'b0;
         lfsr_reg       <= 16'hACE1;
         rsp_valid_reg  <= 1'b0;
         rsp_way_reg    <= '0;
         rsp_evict_reg  <= 1'b0;
         rsp_no_way_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               cnt_reg <= cnt_reg + IdxW'(1);
               if (cnt_reg == IdxW'(NumSets - 1)) begin
                  state_reg     <= ST_RUN;
                  init_done_reg <= 1'b1;
               end
            end
            default: begin
               lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
            end
         endcase
         if (acc) begin
            rsp_valid_reg  <= 1'b1;
            rsp_way_reg    <= sel_way;
            rsp_evict_reg  <= sel_evict;
            rsp_no_way_reg <= sel_no_way;
         end else if (rsp_ready_i) begin
            rsp_valid_reg  <= 1'b0;
         end
      end
   end

`ifdef AXI_LLC_REPL_PERF_EN
   logic        rsp_hit_reg;
   logic        rsp_hs;
   logic [31:0] perf_hit_reg;
   logic [31:0] perf_miss_reg;
   logic [31:0] perf_wb_reg;

   assign rsp_hs = rsp_valid_reg && rsp_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_hit_reg   <= 1'b0;
         perf_hit_reg  <= '0;
         perf_miss_reg <= '0;
         perf_wb_reg   <= '0;
      end else begin
         if (acc) rsp_hit_reg <= req_hit_i;
         if (rsp_hs) begin
            if (rsp_hit_reg && (perf_hit_reg != '1))   perf_hit_reg  <= perf_hit_reg + 32'd1;
            if (!rsp_hit_reg && (perf_miss_reg != '1)) perf_miss_reg <= perf_miss_reg + 32'd1;
            if (rsp_evict_reg && (perf_wb_reg != '1))  perf_wb_reg   <= perf_wb_reg + 32'd1;
         end
      end
   end

   assign perf_hit_o  = perf_hit_reg;
   assign perf_miss_o = perf_miss_reg;
   assign perf_wb_o   = perf_wb_reg;
`else
   assign perf_hit_o  = '0;
   assign perf_miss_o = '0;
   assign perf_wb_o   = '0;
`endif

   always @(posedge clk_i) begin
      if (rst_ni && acc && req_hit_i)
         assert ($onehot(req_hit_way_i)) else $error("req_hit_way_i not onehot on hit");
   end

endmodule

// File: tb/tb_axi_llc_repl_unit.sv
// Randomised bench for axi_llc_repl_unit (4 ways, 4 sets, tree-PLRU) against a range-based PLRU model.
// Perf counters are checked against the model when AXI_LLC_REPL_PERF_EN is defined, else against zero.
module tb_axi_llc_repl_unit;

   typedef struct packed {
      logic [3:0] way;
      logic       evict;
      logic       no_way;
      logic       hit;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_index;
   logic        req_hit;
   logic [3:0]  req_hit_way;
   logic [3:0]  req_valid_ways;
   logic [3:0]  req_dirty_ways;
   logic [3:0]  req_spm_lock;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [3:0]  rsp_way;
   logic        rsp_evict;
   logic        rsp_no_way;
   logic        init_done;
   logic [31:0] perf_hit;
   logic [31:0] perf_miss;
   logic [31:0] perf_wb;

   int   tests;
   int   fails;
   bit   chk_en;
   bit   rnd;
   exp_t expq[$];
   bit   mbits [4][3];
   int   m_hit;
   int   m_miss;
   int   m_wb;

   axi_llc_repl_unit #(.NumWays(4), .NumSets(4), .ReplPolicy(0)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_index_i(req_index),
      .req_hit_i(req_hit), .req_hit_way_i(req_hit_way), .req_valid_ways_i(req_valid_ways),
      .req_dirty_ways_i(req_dirty_ways), .req_spm_lock_i(req_spm_lock),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_way_o(rsp_way),
      .rsp_evict_o(rsp_evict), .rsp_no_way_o(rsp_no_way), .init_done_o(init_done),
      .perf_hit_o(perf_hit), .perf_miss_o(perf_miss), .perf_wb_o(perf_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_clear();
      for (int s = 0; s < 4; s++)
         for (int n = 0; n < 3; n++) mbits[s][n] = 1'b0;
   endfunction

   // Walk by way ranges: bit 0 means lower half; fully locked halves are skipped.
   function automatic int victim(int s, logic [3:0] lk);
      int lo = 0, size = 4, node = 0, half;
      bit hi, lo_lk, hi_lk;
      while (size > 1) begin
         half  = size / 2;
         lo_lk = 1'b1;
         hi_lk = 1'b1;
         for (int i = 0; i < half; i++) begin
            if (!lk[lo + i]) lo_lk = 1'b0;
            if (!lk[lo + half + i]) hi_lk = 1'b0;
         end
         hi = mbits[s][node];
         if (hi && hi_lk) hi = 1'b0;
         else if (!hi && lo_lk) hi = 1'b1;
         if (hi) lo += half;
         node = 2 * node + 1 + (hi ? 1 : 0);
         size = half;
      end
      return lo;
   endfunction

   function automatic void touch(int s, int w);
      int lo = 0, size = 4, node = 0, half;
      bit upper;
      while (size > 1) begin
         half  = size / 2;
         upper = (w >= lo + half);
         mbits[s][node] = !upper;
         if (upper) lo += half;
         node = 2 * node + 1 + (upper ? 1 : 0);
         size = half;
      end
   endfunction

   function automatic exp_t model_apply(int s, bit hit, logic [3:0] hw, logic [3:0] vw,
                                        logic [3:0] dw, logic [3:0] lk);
      exp_t e;
      int   w = -1;
      e = '0;
      e.hit = hit;
      if (hit) begin
         e.way = hw;
         for (int i = 0; i < 4; i++) if (hw[i]) w = i;
         touch(s, w);
      end else if (lk == 4'hF) begin
         e.no_way = 1'b1;
      end else begin
         for (int i = 3; i >= 0; i--) if (!vw[i] && !lk[i]) w = i;
         if (w < 0) begin
            w = victim(s, lk);
            e.evict = dw[w];
         end
         e.way = 4'(1 << w);
         touch(s, w);
      end
      return e;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int s, input bit hit, input logic [3:0] hw, input logic [3:0] vw,
                       input logic [3:0] dw, input logic [3:0] lk);
      bit ok = 1'b0;
      req_valid      = 1'b1;
      req_index      = 2'(s);
      req_hit        = hit;
      req_hit_way    = hw;
      req_valid_ways = vw;
      req_dirty_ways = dw;
      req_spm_lock   = lk;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL accept_timeout: req_ready stayed %0b, required 1 within 50 cycles", req_ready);
      end else begin
         @(posedge clk);
         expq.push_back(model_apply(s, hit, hw, vw, dw, lk));
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic expect_lit(input string name, input logic [3:0] way, input bit ev, input bit nw);
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_way !== way || rsp_evict !== ev || rsp_no_way !== nw) begin
         fails++;
         $display("FAIL %s: got valid=%0b way=%b evict=%0b no_way=%0b, required valid=1 way=%b evict=%0b no_way=%0b",
                  name, rsp_valid, rsp_way, rsp_evict, rsp_no_way, way, ev, nw);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_init(input string name);
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) break;
         n++;
      end
      tests++;
      if (n != 4 || init_done !== 1'b1) begin
         fails++;
         $display("FAIL %s: ready-low cycles=%0d init_done=%0b, required 4 and 1", name, n, init_done);
      end
      @(posedge clk);
      #1;
   endtask

   // Per-cycle checker: handshake rule, response contents against the model queue, perf counters.
   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         m_hit  = 0;
         m_miss = 0;
         m_wb   = 0;
      end else if (chk_en) begin
         tests++;
`ifdef AXI_LLC_REPL_PERF_EN
         if (perf_hit !== 32'(m_hit) || perf_miss !== 32'(m_miss) || perf_wb !== 32'(m_wb)) begin
            fails++;
            $display("FAIL perf: got %0d/%0d/%0d, required %0d/%0d/%0d",
                     perf_hit, perf_miss, perf_wb, m_hit, m_miss, m_wb);
         end
`else
         if (perf_hit !== 32'd0 || perf_miss !== 32'd0 || perf_wb !== 32'd0) begin
            fails++;
            $display("FAIL perf_tied: got %0d/%0d/%0d, required 0/0/0", perf_hit, perf_miss, perf_wb);
         end
`endif
         tests++;
         if (req_ready !== ((!rsp_valid) | rsp_ready)) begin
            fails++;
            $display("FAIL req_ready: got %0b, required %0b", req_ready, (!rsp_valid) | rsp_ready);
         end
         tests++;
         if (rsp_valid !== (expq.size() != 0)) begin
            fails++;
            $display("FAIL rsp_valid: got %0b, required %0b", rsp_valid, expq.size() != 0);
         end else if (rsp_valid) begin
            tests++;
            if (rsp_way !== expq[0].way || rsp_evict !== expq[0].evict || rsp_no_way !== expq[0].no_way) begin
               fails++;
               $display("FAIL rsp: got way=%b evict=%0b no_way=%0b, required way=%b evict=%0b no_way=%0b",
                        rsp_way, rsp_evict, rsp_no_way, expq[0].way, expq[0].evict, expq[0].no_way);
            end
            if (rsp_ready) begin
               if (expq[0].hit) m_hit++;
               else m_miss++;
               if (expq[0].evict) m_wb++;
               void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      logic [3:0] hw, vw, dw, lk;
      bit         hit;
      int         r, idle;
      tests = 0; fails = 0; chk_en = 1'b0; rnd = 1'b0;
      rst_n = 1'b0; req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_hit_way = '0;
      req_valid_ways = '0; req_dirty_ways = '0; req_spm_lock = '0; rsp_ready = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0 || rsp_way !== 4'b0 || rsp_evict !== 1'b0 || rsp_no_way !== 1'b0 ||
          init_done !== 1'b0 || req_ready !== 1'b0 || perf_hit !== 32'd0) begin
         fails++;
         $display("FAIL reset_state: valid=%0b way=%b evict=%0b no_way=%0b init=%0b ready=%0b, required all 0",
                  rsp_valid, rsp_way, rsp_evict, rsp_no_way, init_done, req_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_init("init_sweep");
      chk_en = 1'b1;

      send(1, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000); expect_lit("free_way",  4'b0010, 0, 0);
      send(2, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000); expect_lit("plru_1st",  4'b0001, 0, 0);
      send(2, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000); expect_lit("plru_2nd",  4'b0100, 0, 0);
      send(2, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000); expect_lit("plru_3rd",  4'b0010, 0, 0);
      send(3, 1, 4'b0100, 4'b1111, 4'b0000, 4'b0000); expect_lit("hit_way",   4'b0100, 0, 0);
      send(3, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000); expect_lit("after_hit", 4'b0001, 0, 0);
      send(0, 0, 4'b0000, 4'b1111, 4'b0100, 4'b0011); expect_lit("lock_skip", 4'b0100, 1, 0);
      send(2, 0, 4'b0000, 4'b1111, 4'b1111, 4'b1111); expect_lit("no_way",    4'b0000, 0, 1);
      send(2, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000); expect_lit("unchanged", 4'b1000, 0, 0);

      @(negedge clk);
      tests++;
`ifdef AXI_LLC_REPL_PERF_EN
      if (perf_hit !== 32'd1 || perf_miss !== 32'd8 || perf_wb !== 32'd1) begin
         fails++;
         $display("FAIL perf_directed: got %0d/%0d/%0d, required 1/8/1", perf_hit, perf_miss, perf_wb);
      end
`else
      if (perf_hit !== 32'd0 || perf_miss !== 32'd0 || perf_wb !== 32'd0) begin
         fails++;
         $display("FAIL perf_directed: got %0d/%0d/%0d, required 0/0/0", perf_hit, perf_miss, perf_wb);
      end
`endif
      @(posedge clk);
      #1;

      rsp_ready = 1'b0;
      send(1, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid !== 1'b1 || rsp_way !== 4'b0100 || rsp_evict !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure: got valid=%0b way=%b evict=%0b ready=%0b, required 1 0100 1 0",
                     rsp_valid, rsp_way, rsp_evict, req_ready);
         end
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1;

      rnd = 1'b1;
      for (int n = 0; n < 400; n++) begin
         idle = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         repeat (idle) begin
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         hit = ($urandom_range(0, 3) == 0);
         hw  = 4'(1 << $urandom_range(0, 3));
         vw  = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
         dw  = 4'($urandom);
         r   = $urandom_range(0, 9);
         lk  = (r == 0) ? 4'hF : ((r < 4) ? 4'($urandom) : 4'h0);
         if (hit) vw = vw | hw;
         else hw = 4'h0;
         send($urandom_range(0, 3), hit, hw, vw, dw, lk);
      end
      rnd = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!rsp_valid) break;
      end
      @(posedge clk);
      #1;

      rsp_ready = 1'b0;
      send(0, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
      @(posedge clk);
      #1 chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      tests++;
      if (rsp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0 || rsp_way !== 4'b0 ||
          perf_miss !== 32'd0) begin
         fails++;
         $display("FAIL midop_reset: valid=%0b init=%0b ready=%0b way=%b miss=%0d, required all 0",
                  rsp_valid, init_done, req_ready, rsp_way, perf_miss);
      end
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_init("reinit_sweep");
      rsp_ready = 1'b1;
      chk_en = 1'b1;
      send(2, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000); expect_lit("post_reset", 4'b0001, 0, 0);
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
